// File: rtl/param_shift_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : param_shift_reg_if
//  Description : Bus bundle for param_shift_reg. The master side (the
//                datapath driving the register) supplies the control and
//                data inputs; the slave side (the shift register) returns
//                the register contents, serial output and burst status.
//
//  Signals     : en        - clock enable for all updates and burst progress
//                mode      - operation select (HOLD/SR/SL/RR/RL/LOAD)
//                sin       - serial input bit for shift modes
//                pdata_in  - parallel load data
//                start     - burst request, sampled while idle
//                count     - number of burst shifts
//                pdata_out - current register contents
//                sout      - registered bit last shifted/rotated out
//                busy      - burst in progress
//                done      - one-cycle pulse after the final burst shift
//
//  Revision    : 1.0  initial release
// ============================================================================
interface param_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] pdata_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] pdata_out;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, sin, pdata_in, start, count,
        input  pdata_out, sout, busy, done
    );

    modport slave (
        input  en, mode, sin, pdata_in, start, count,
        output pdata_out, sout, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/param_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : param_shift_reg
//  Description : WIDTH-bit universal register: parallel load, shift
//                left/right and rotate left/right, with clock enable,
//                registered serial output and a counted burst-shift engine
//                that performs 'count' shifts autonomously.
//
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-high reset (overrides en)
//                bus    - param_shift_reg_if.slave (control, data, status)
//
//  Mode codes  : 0 HOLD, 1 SR, 2 SL, 3 RR, 4 RL, 5 LOAD, 6/7 HOLD
//
//  Notes       : The interface instance must be parameterised with the same
//                WIDTH and CNT_W as this module.
//
//  Revision    : 1.0  initial release
// ============================================================================
module param_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    param_shift_reg_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_MODE_HOLD = 3'd0;
    localparam logic [2:0] c_MODE_SR   = 3'd1;
    localparam logic [2:0] c_MODE_SL   = 3'd2;
    localparam logic [2:0] c_MODE_RR   = 3'd3;
    localparam logic [2:0] c_MODE_RL   = 3'd4;
    localparam logic [2:0] c_MODE_LOAD = 3'd5;

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_BURST = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_reg;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
    logic [0:0]       r_state;
    logic [2:0]       r_bmode;
    logic [CNT_W-1:0] r_rem;

    // ------------------------------------------------------------------
    // Next-value datapath
    // ------------------------------------------------------------------
    logic [2:0]       w_op;
    logic             w_mode_is_shift;
    logic [WIDTH-1:0] w_next_reg;
    logic             w_next_sout;

    // During a burst the latched mode drives the datapath and the live
    // mode input is ignored. A latched mode is always one of SR/SL/RR/RL,
    // so the LOAD arm below is only reachable from IDLE.
    assign w_op            = (r_state == c_S_BURST) ? r_bmode : bus.mode;
    assign w_mode_is_shift = (bus.mode >= c_MODE_SR) && (bus.mode <= c_MODE_RL);

    always_comb begin
        w_next_reg  = r_reg;
        w_next_sout = r_sout;
        case (w_op)
            c_MODE_SR: begin
                w_next_reg  = {bus.sin, r_reg[WIDTH-1:1]};
                w_next_sout = r_reg[0];
            end
            c_MODE_SL: begin
                w_next_reg  = {r_reg[WIDTH-2:0], bus.sin};
                w_next_sout = r_reg[WIDTH-1];
            end
            c_MODE_RR: begin
                w_next_reg  = {r_reg[0], r_reg[WIDTH-1:1]};
                w_next_sout = r_reg[0];
            end
            c_MODE_RL: begin
                w_next_reg  = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
                w_next_sout = r_reg[WIDTH-1];
            end
            c_MODE_LOAD: begin
                w_next_reg  = bus.pdata_in;
            end
            c_MODE_HOLD: begin
            end
            default: begin
                // codes 6 and 7 hold
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register, serial output and burst controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg   <= RESET_VAL;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= c_S_IDLE;
            r_bmode <= c_MODE_HOLD;
            r_rem   <= c_CNT_ZERO;
        end else begin
            // done is a single-cycle pulse; it is cleared even when stalled
            r_done <= 1'b0;
            if (bus.en) begin
                case (r_state)
                    c_S_IDLE: begin
                        if (bus.start && w_mode_is_shift) begin
                            // A burst request wins over the single op; the
                            // register is untouched on the accepting edge.
                            if (bus.count != c_CNT_ZERO) begin
                                r_bmode <= bus.mode;
                                r_rem   <= bus.count;
                                r_state <= c_S_BURST;
                                r_busy  <= 1'b1;
                            end else begin
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_reg  <= w_next_reg;
                            r_sout <= w_next_sout;
                        end
                    end
                    c_S_BURST: begin
                        r_reg  <= w_next_reg;
                        r_sout <= w_next_sout;
                        r_rem  <= r_rem - c_CNT_ONE;
                        if (r_rem == c_CNT_ONE) begin
                            r_state <= c_S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pdata_out = r_reg;
    assign bus.sout      = r_sout;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_param_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_shift_reg
//  Description : Directed self-checking bench for param_shift_reg. A 4-bit
//                instance exercises the serial delay path; an 8-bit instance
//                covers load/rotate, bursts, stalls, edge cases and reset.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_shift_reg;

    logic clk;
    logic reset;

    int n_total;
    int n_pass;
    int n_fail;

    param_shift_reg_if #(.WIDTH(4), .CNT_W(4)) if4 ();
    param_shift_reg_if #(.WIDTH(8), .CNT_W(4)) if8 ();

    param_shift_reg #(.WIDTH(4), .CNT_W(4), .RESET_VAL(4'h0)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    param_shift_reg #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // serial delay vectors for the 4-bit SR chain (one entry per edge)
    logic       sin_seq [12];
    logic [3:0] exp_p4  [12];
    logic       exp_s4  [12];

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;

        sin_seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0};
        exp_p4  = '{4'h0, 4'h0, 4'h8, 4'hC, 4'h6, 4'h3, 4'h9, 4'hC,
                    4'h6, 4'h3, 4'h1, 4'h0};
        exp_s4  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b1};

        if4.en = 1'b0; if4.mode = 3'd0; if4.sin = 1'b0;
        if4.pdata_in = 4'h0; if4.start = 1'b0; if4.count = 4'd0;
        if8.en = 1'b0; if8.mode = 3'd0; if8.sin = 1'b0;
        if8.pdata_in = 8'h00; if8.start = 1'b0; if8.count = 4'd0;

        // ---------------- reset state ----------------
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst4_pdata", {28'd0, if4.pdata_out}, 32'h0);
        chk("rst4_sout",  {31'd0, if4.sout},      32'h0);
        chk("rst8_pdata", {24'd0, if8.pdata_out}, 32'h0);
        chk("rst8_busy",  {31'd0, if8.busy},      32'h0);
        chk("rst8_done",  {31'd0, if8.done},      32'h0);

        // ---------------- serial delay, WIDTH=4 ----------------
        if4.en   = 1'b1;
        if4.mode = 3'd1;
        for (int i = 0; i < 12; i++) begin
            if4.sin = sin_seq[i];
            tick();
            chk($sformatf("ser_pdata[%0d]", i), {28'd0, if4.pdata_out}, {28'd0, exp_p4[i]});
            chk($sformatf("ser_sout[%0d]", i),  {31'd0, if4.sout},      {31'd0, exp_s4[i]});
        end
        if4.en = 1'b0;

        // ---------------- load and rotate, WIDTH=8 ----------------
        if8.en = 1'b1;
        if8.mode = 3'd5; if8.pdata_in = 8'hA5;
        tick();
        chk("load_a5", {24'd0, if8.pdata_out}, 32'hA5);
        if8.mode = 3'd3;
        tick();
        chk("rr_pdata", {24'd0, if8.pdata_out}, 32'hD2);
        chk("rr_sout",  {31'd0, if8.sout},      32'h1);
        if8.mode = 3'd4;
        tick();
        chk("rl_pdata", {24'd0, if8.pdata_out}, 32'hA5);
        chk("rl_sout",  {31'd0, if8.sout},      32'h1);

        // ---------------- burst SL count=3 ----------------
        if8.mode = 3'd5; if8.pdata_in = 8'h81;
        tick();
        if8.mode = 3'd2; if8.count = 4'd3; if8.sin = 1'b1; if8.start = 1'b1;
        tick();
        chk("bsl_acc_busy",  {31'd0, if8.busy},      32'h1);
        chk("bsl_acc_pdata", {24'd0, if8.pdata_out}, 32'h81);
        if8.start = 1'b0; if8.mode = 3'd0; if8.pdata_in = 8'hFF;
        tick();
        chk("bsl_s1_pdata", {24'd0, if8.pdata_out}, 32'h03);
        chk("bsl_s1_busy",  {31'd0, if8.busy},      32'h1);
        tick();
        chk("bsl_s2_pdata", {24'd0, if8.pdata_out}, 32'h07);
        chk("bsl_s2_busy",  {31'd0, if8.busy},      32'h1);
        tick();
        chk("bsl_s3_pdata", {24'd0, if8.pdata_out}, 32'h0F);
        chk("bsl_s3_sout",  {31'd0, if8.sout},      32'h0);
        chk("bsl_s3_busy",  {31'd0, if8.busy},      32'h0);
        chk("bsl_s3_done",  {31'd0, if8.done},      32'h1);
        tick();
        chk("bsl_post_done",  {31'd0, if8.done},      32'h0);
        chk("bsl_post_pdata", {24'd0, if8.pdata_out}, 32'h0F);

        // ---------------- burst RR count=4 with 2-cycle stall ----------------
        if8.mode = 3'd5; if8.pdata_in = 8'hF0;
        tick();
        if8.mode = 3'd3; if8.count = 4'd4; if8.start = 1'b1;
        tick();
        chk("bst_acc_busy", {31'd0, if8.busy}, 32'h1);
        if8.start = 1'b0; if8.mode = 3'd5; if8.pdata_in = 8'h55;
        tick();
        chk("bst_s1_pdata", {24'd0, if8.pdata_out}, 32'h78);
        if8.en = 1'b0;
        tick();
        chk("bst_stall1_busy",  {31'd0, if8.busy},      32'h1);
        chk("bst_stall1_pdata", {24'd0, if8.pdata_out}, 32'h78);
        tick();
        chk("bst_stall2_busy",  {31'd0, if8.busy},      32'h1);
        chk("bst_stall2_done",  {31'd0, if8.done},      32'h0);
        if8.en = 1'b1;
        tick();
        chk("bst_s2_pdata", {24'd0, if8.pdata_out}, 32'h3C);
        chk("bst_s2_busy",  {31'd0, if8.busy},      32'h1);
        tick();
        chk("bst_s3_pdata", {24'd0, if8.pdata_out}, 32'h1E);
        chk("bst_s3_done",  {31'd0, if8.done},      32'h0);
        tick();
        chk("bst_s4_pdata", {24'd0, if8.pdata_out}, 32'h0F);
        chk("bst_s4_busy",  {31'd0, if8.busy},      32'h0);
        chk("bst_s4_done",  {31'd0, if8.done},      32'h1);
        if8.mode = 3'd0;
        tick();
        chk("bst_post_done", {31'd0, if8.done}, 32'h0);

        // ---------------- edge cases ----------------
        if8.mode = 3'd1; if8.count = 4'd0; if8.start = 1'b1;
        tick();
        chk("cnt0_done",  {31'd0, if8.done},      32'h1);
        chk("cnt0_busy",  {31'd0, if8.busy},      32'h0);
        chk("cnt0_pdata", {24'd0, if8.pdata_out}, 32'h0F);
        if8.start = 1'b0; if8.mode = 3'd0;
        tick();
        chk("cnt0_post_done", {31'd0, if8.done}, 32'h0);
        if8.mode = 3'd5; if8.pdata_in = 8'h3C; if8.count = 4'd2; if8.start = 1'b1;
        tick();
        chk("start_load_pdata", {24'd0, if8.pdata_out}, 32'h3C);
        chk("start_load_busy",  {31'd0, if8.busy},      32'h0);
        if8.start = 1'b0; if8.mode = 3'd6; if8.pdata_in = 8'hFF;
        tick();
        chk("mode6_hold", {24'd0, if8.pdata_out}, 32'h3C);
        if8.mode = 3'd7;
        tick();
        chk("mode7_hold", {24'd0, if8.pdata_out}, 32'h3C);

        // ---------------- reset mid-burst ----------------
        if8.mode = 3'd5; if8.pdata_in = 8'h01;
        tick();
        if8.mode = 3'd4; if8.count = 4'd8; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick();
        tick();
        tick();
        chk("rmb_3shifts", {24'd0, if8.pdata_out}, 32'h08);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmb_pdata", {24'd0, if8.pdata_out}, 32'h00);
        chk("rmb_busy",  {31'd0, if8.busy},      32'h0);
        chk("rmb_done",  {31'd0, if8.done},      32'h0);
        if8.mode = 3'd0;
        tick();
        chk("rmb_post_done", {31'd0, if8.done}, 32'h0);
        chk("rmb_post_busy", {31'd0, if8.busy}, 32'h0);

        // new burst after reset, then a back-to-back full-width rotate
        if8.mode = 3'd5; if8.pdata_in = 8'h01;
        tick();
        if8.mode = 3'd4; if8.count = 4'd1; if8.start = 1'b1;
        tick();
        chk("nb_acc_busy", {31'd0, if8.busy}, 32'h1);
        if8.start = 1'b0;
        tick();
        chk("nb_pdata", {24'd0, if8.pdata_out}, 32'h02);
        chk("nb_done",  {31'd0, if8.done},      32'h1);
        if8.mode = 3'd3; if8.count = 4'd8; if8.start = 1'b1;
        tick();
        chk("b2b_acc_busy", {31'd0, if8.busy}, 32'h1);
        if8.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_s7_busy", {31'd0, if8.busy}, 32'h1);
        tick();
        chk("b2b_pdata", {24'd0, if8.pdata_out}, 32'h02);
        chk("b2b_done",  {31'd0, if8.done},      32'h1);
        chk("b2b_busy",  {31'd0, if8.busy},      32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
